m_proc_pipe: RTL and testbench

Parametrised five-stage pipelined successor to the single-cycle RV32 subset core (IF, ID, EX, MA, WB). It executes the same instruction subset and decode rules, with the same x30 halt convention. It adds an asynchronous reset, data forwarding (selectable), load-use interlock, branch flush, and a sticky halt output in place of `$finish`. It sits under `m_sim`-style wrappers; memories stay internal arrays named `mem` so benches preload them hierarchically.

---
 rtl/m_proc_pipe.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_m_proc_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_proc_pipe.sv
// Five-stage pipelined RV32 subset core (IF, ID, EX, MA, WB) with forwarding, load-use interlock and halt.
// Latency: an instruction retires on the 5th rising edge after it enters IF; independent ones retire every cycle.
// Backpressure: RAW hazards stall IF/ID and insert an EX bubble; a taken branch squashes IF/ID and ID/EX.
//
// Ports:
//   w_clk      single clock, all state on rising edge
//   w_rst      asynchronous active-high reset (PC, valid bits, halt, retire)
//   w_halt     sticky, set when an instruction writing x30 retires
//   w_retire   one-cycle pulse per instruction completing WB
//   w_pc       current IF-stage PC
//   w_dbg_ra   debug register-file read address
//   w_dbg_rd   combinational read of register w_dbg_ra (0 for x0)

// Word-addressed memory with asynchronous read and a synchronous write port.
// Latency: read is combinational, write lands on the rising edge.
// Backpressure: none.
module m_proc_mem #(
    parameter int WORDS = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdat,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdat
);
    // Not reset; benches preload this array hierarchically.
    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdat;
        end
    end

    assign rdat = mem[raddr];
endmodule

module m_proc_pipe #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64,
    parameter int FORWARD    = 1
) (
    input  logic        w_clk,
    input  logic        w_rst,
    output logic        w_halt,
    output logic        w_retire,
    output logic [31:0] w_pc,
    input  logic [4:0]  w_dbg_ra,
    output logic [31:0] w_dbg_rd
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    localparam logic [4:0] OP_R  = 5'b01100;
    localparam logic [4:0] OP_LD = 5'b00000;
    localparam logic [4:0] OP_ST = 5'b01000;
    localparam logic [4:0] OP_BR = 5'b11000;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic [31:0] ir;
    } ifid_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wr;
        logic        ld;
        logic        st;
        logic        br;
        logic        r;
        logic [31:0] imm;
        logic [31:0] a;
        logic [31:0] b;
    } idex_t;

    typedef struct packed {
        logic        vld;
        logic [4:0]  rd;
        logic        wr;
        logic        ld;
        logic        st;
        logic [31:0] res;
        logic [31:0] sd;
    } exma_t;

    typedef struct packed {
        logic        vld;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] res;
    } mawb_t;

    logic [31:0] pc_q;
    logic        halt_q;
    logic        retire_q;
    ifid_t       ifid_q;
    idex_t       idex_q, id_dec;
    exma_t       exma_q, ex_nxt;
    mawb_t       mawb_q, ma_nxt;

    logic [31:0] rf [32];
    logic [31:0] imem_rdat, dmem_rdat;

    // ---------------- IF ----------------
    m_proc_mem #(.WORDS(IMEM_WORDS), .AW(IAW)) u_imem (
        .clk   (w_clk),
        .we    (1'b0),
        .waddr ('0),
        .wdat  ('0),
        .raddr (pc_q[IAW+1:2]),
        .rdat  (imem_rdat)
    );

    // ---------------- ID ----------------
    logic [4:0]  id_opc, id_rd, id_rs1, id_rs2;
    logic        id_r, id_ld, id_st, id_br, id_use2;
    logic [31:0] imm_i, imm_s, imm_b, id_a, id_b;
    logic        rf_we;
    logic        unused_ir_bits;

    assign id_opc  = ifid_q.ir[6:2];
    assign id_rd   = ifid_q.ir[11:7];
    assign id_rs1  = ifid_q.ir[19:15];
    assign id_rs2  = ifid_q.ir[24:20];
    assign id_r    = (id_opc == OP_R);
    assign id_ld   = (id_opc == OP_LD);
    assign id_st   = (id_opc == OP_ST);
    assign id_br   = (id_opc == OP_BR);
    assign id_use2 = id_r || id_st || id_br;

    assign imm_i = {{20{ifid_q.ir[31]}}, ifid_q.ir[31:20]};
    assign imm_s = {{20{ifid_q.ir[31]}}, ifid_q.ir[31:25], ifid_q.ir[11:7]};
    assign imm_b = {{19{ifid_q.ir[31]}}, ifid_q.ir[31], ifid_q.ir[7],
                    ifid_q.ir[30:25], ifid_q.ir[11:8], 1'b0};

    // funct3 and the low opcode bits play no part in this subset's decode.
    assign unused_ir_bits = ^{ifid_q.ir[14:12], ifid_q.ir[1:0]};

    assign rf_we = mawb_q.vld && mawb_q.wr && (mawb_q.rd != 5'd0);

    // Write-through: a WB write to the register being read shows up in the same cycle.
    assign id_a = (id_rs1 == 5'd0) ? 32'd0 :
                  (rf_we && (mawb_q.rd == id_rs1)) ? mawb_q.res : rf[id_rs1];
    assign id_b = (id_rs2 == 5'd0) ? 32'd0 :
                  (rf_we && (mawb_q.rd == id_rs2)) ? mawb_q.res : rf[id_rs2];

    always_comb begin
        id_dec     = '0;
        id_dec.vld = ifid_q.vld;
        id_dec.pc  = ifid_q.pc;
        id_dec.rd  = id_rd;
        id_dec.rs1 = id_rs1;
        id_dec.rs2 = id_rs2;
        id_dec.wr  = !(id_st || id_br);
        id_dec.ld  = id_ld;
        id_dec.st  = id_st;
        id_dec.br  = id_br;
        id_dec.r   = id_r;
        id_dec.imm = id_st ? imm_s : (id_br ? imm_b : imm_i);
        id_dec.a   = id_a;
        id_dec.b   = id_b;
    end

    // Hazard detection: does the ID instruction read the rd of an older in-flight producer?
    logic haz_ex, haz_ma, stall;

    assign haz_ex = idex_q.vld && idex_q.wr && (idex_q.rd != 5'd0) &&
                    ((idex_q.rd == id_rs1) || (id_use2 && (idex_q.rd == id_rs2)));
    assign haz_ma = exma_q.vld && exma_q.wr && (exma_q.rd != 5'd0) &&
                    ((exma_q.rd == id_rs1) || (id_use2 && (exma_q.rd == id_rs2)));

    // With bypass only a load in EX is too late to forward; without it, wait until WB.
    assign stall = ifid_q.vld &&
                   ((FORWARD != 0) ? (haz_ex && idex_q.ld) : (haz_ex || haz_ma));

    // ---------------- EX ----------------
    logic [31:0] ma_res;

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] idv,
                                        input exma_t ma, input logic [31:0] ma_v,
                                        input mawb_t wb);
        if ((FORWARD != 0) && ma.vld && ma.wr && (ma.rd != 5'd0) && (ma.rd == rs)) begin
            return ma_v;
        end else if ((FORWARD != 0) && wb.vld && wb.wr && (wb.rd != 5'd0) && (wb.rd == rs)) begin
            return wb.res;
        end
        return idv;
    endfunction

    logic [31:0] ex_a, ex_b, ex_target;
    logic        ex_taken;

    assign ex_a      = fwd(idex_q.rs1, idex_q.a, exma_q, ma_res, mawb_q);
    assign ex_b      = fwd(idex_q.rs2, idex_q.b, exma_q, ma_res, mawb_q);
    assign ex_taken  = idex_q.vld && idex_q.br && (ex_a != ex_b);
    assign ex_target = idex_q.pc + idex_q.imm;

    always_comb begin
        ex_nxt     = '0;
        ex_nxt.vld = idex_q.vld;
        ex_nxt.rd  = idex_q.rd;
        ex_nxt.wr  = idex_q.wr;
        ex_nxt.ld  = idex_q.ld;
        ex_nxt.st  = idex_q.st;
        ex_nxt.res = ex_a + (idex_q.r ? ex_b : idex_q.imm);
        ex_nxt.sd  = ex_b;
    end

    // ---------------- MA ----------------
    logic wb_halt, dmem_we;

    assign wb_halt = mawb_q.vld && mawb_q.wr && (mawb_q.rd == 5'd30);
    // A store younger than the halting instruction must not land.
    assign dmem_we = exma_q.vld && exma_q.st && !wb_halt;

    m_proc_mem #(.WORDS(DMEM_WORDS), .AW(DAW)) u_dmem (
        .clk   (w_clk),
        .we    (dmem_we),
        .waddr (exma_q.res[DAW+1:2]),
        .wdat  (exma_q.sd),
        .raddr (exma_q.res[DAW+1:2]),
        .rdat  (dmem_rdat)
    );

    assign ma_res = exma_q.ld ? dmem_rdat : exma_q.res;

    always_comb begin
        ma_nxt     = '0;
        ma_nxt.vld = exma_q.vld;
        ma_nxt.rd  = exma_q.rd;
        ma_nxt.wr  = exma_q.wr;
        ma_nxt.res = ma_res;
    end

    // ---------------- WB ----------------
    always_ff @(posedge w_clk) begin
        if (rf_we) begin
            rf[mawb_q.rd] <= mawb_q.res;
        end
    end

    // ---------------- pipeline control ----------------
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            pc_q     <= 32'd0;
            halt_q   <= 1'b0;
            retire_q <= 1'b0;
            ifid_q   <= '0;
            idex_q   <= '0;
            exma_q   <= '0;
            mawb_q   <= '0;
        end else if (halt_q) begin
            retire_q <= 1'b0;
        end else begin
            retire_q <= mawb_q.vld;
            if (wb_halt) begin
                // The halting instruction still writes and retires; everything younger dies.
                halt_q     <= 1'b1;
                ifid_q.vld <= 1'b0;
                idex_q.vld <= 1'b0;
                exma_q.vld <= 1'b0;
                mawb_q.vld <= 1'b0;
            end else begin
                mawb_q <= ma_nxt;
                exma_q <= ex_nxt;
                if (ex_taken) begin
                    // Older branch wins over any stall of the instruction behind it.
                    pc_q       <= ex_target;
                    ifid_q.vld <= 1'b0;
                    idex_q.vld <= 1'b0;
                end else if (stall) begin
                    idex_q.vld <= 1'b0;
                end else begin
                    pc_q       <= pc_q + 32'd4;
                    ifid_q.vld <= 1'b1;
                    ifid_q.pc  <= pc_q;
                    ifid_q.ir  <= imem_rdat;
                    idex_q     <= id_dec;
                end
            end
        end
    end

    assign w_halt   = halt_q;
    assign w_retire = retire_q;
    assign w_pc     = pc_q;
    assign w_dbg_rd = (w_dbg_ra == 5'd0) ? 32'd0 : rf[w_dbg_ra];
endmodule

// File: tb/tb_m_proc_pipe.sv
// Bench for m_proc_pipe: runs directed programs on a bypassing and an interlock-only instance.
// Latency: retire and halt timing are measured against hand-computed cycle lists.
// Backpressure: n/a (closed system, programs preloaded hierarchically).
module tb_m_proc_pipe;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  dbg_ra = 5'd0;
    logic        halt1, ret1, halt0, ret0;
    logic [31:0] pc1, pc0, dbg1, dbg0;

    m_proc_pipe #(.IMEM_WORDS(64), .DMEM_WORDS(64), .FORWARD(1)) dut1 (
        .w_clk(clk), .w_rst(rst), .w_halt(halt1), .w_retire(ret1),
        .w_pc(pc1), .w_dbg_ra(dbg_ra), .w_dbg_rd(dbg1)
    );

    m_proc_pipe #(.IMEM_WORDS(64), .DMEM_WORDS(64), .FORWARD(0)) dut0 (
        .w_clk(clk), .w_rst(rst), .w_halt(halt0), .w_retire(ret0),
        .w_pc(pc0), .w_dbg_ra(dbg_ra), .w_dbg_rd(dbg0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // cyc == n after the n-th rising edge following reset release.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int ret_q1[$], ret_q0[$];
    int hc1, hc0;
    always @(negedge clk) begin
        if (ret1) ret_q1.push_back(cyc);
        if (ret0) ret_q0.push_back(cyc);
        if (halt1 && hc1 == 0) hc1 = cyc;
        if (halt0 && hc0 == 0) hc0 = cyc;
    end

    // ---------------- encoders (standard RV32 formats) ----------------
    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        logic [11:0] im; logic [4:0] d, s;
        im = imm[11:0]; d = rd[4:0]; s = rs1[4:0];
        return {im, s, 3'b000, d, 7'b0010011};
    endfunction
    function automatic logic [31:0] add(int rd, int rs1, int rs2);
        logic [4:0] d, s, t;
        d = rd[4:0]; s = rs1[4:0]; t = rs2[4:0];
        return {7'b0, t, s, 3'b000, d, 7'b0110011};
    endfunction
    function automatic logic [31:0] lw(int rd, int rs1, int imm);
        logic [11:0] im; logic [4:0] d, s;
        im = imm[11:0]; d = rd[4:0]; s = rs1[4:0];
        return {im, s, 3'b010, d, 7'b0000011};
    endfunction
    function automatic logic [31:0] sw(int rs2, int rs1, int imm);
        logic [11:0] im; logic [4:0] s, t;
        im = imm[11:0]; s = rs1[4:0]; t = rs2[4:0];
        return {im[11:5], t, s, 3'b010, im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] bne(int rs1, int rs2, int imm);
        logic [12:0] im; logic [4:0] s, t;
        im = imm[12:0]; s = rs1[4:0]; t = rs2[4:0];
        return {im[12], im[10:5], t, s, 3'b001, im[4:1], im[11], 7'b1100011};
    endfunction

    logic [31:0] prog [4][8];
    int          plen [4];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_q(string name, input int act[$], input int exp[$]);
        int bad;
        bad = -1;
        checks++;
        if (act.size() != exp.size()) bad = 0;
        else foreach (exp[i]) if (bad < 0 && act[i] != exp[i]) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: got %0d retires (first differing at index %0d: %0d), expected %0d retires (%0d)",
                     name, act.size(), bad, (bad < act.size()) ? act[bad] : -1,
                     exp.size(), (bad < exp.size()) ? exp[bad] : -1);
        end
    endtask

    task automatic load(int p);
        for (int i = 0; i < 64; i++) begin
            dut1.u_imem.mem[i] = NOP;
            dut0.u_imem.mem[i] = NOP;
            dut1.u_dmem.mem[i] = 32'd0;
            dut0.u_dmem.mem[i] = 32'd0;
        end
        for (int i = 0; i < plen[p]; i++) begin
            dut1.u_imem.mem[i] = prog[p][i];
            dut0.u_imem.mem[i] = prog[p][i];
        end
        if (p == 1) begin
            dut1.u_dmem.mem[2] = 32'd7;
            dut0.u_dmem.mem[2] = 32'd7;
        end
    endtask

    task automatic start_prog(int p);
        rst = 1'b1;
        @(negedge clk);
        load(p);
        ret_q1.delete();
        ret_q0.delete();
        hc1 = 0;
        hc0 = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_halt(string name);
        int n;
        n = 0;
        while (!(halt1 && halt0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk({"halt reached ", name}, {31'd0, halt1 && halt0}, 32'd1);
    endtask

    typedef struct {
        int          p;
        int          ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];
    int   exp_q[$];

    initial begin
        int cur, n, nret, lowc;
        logic [31:0] pc_snap;

        // Programs: p0 dependent adds, p1 load-use, p2 bne loop, p3 store/load.
        prog[0][0] = addi(1, 0, 5);  prog[0][1] = addi(2, 1, 3);
        prog[0][2] = add(3, 1, 2);   prog[0][3] = addi(30, 0, 1);  plen[0] = 4;
        prog[1][0] = lw(1, 0, 8);    prog[1][1] = add(2, 1, 1);
        prog[1][2] = addi(30, 0, 1); plen[1] = 3;
        prog[2][0] = addi(1, 0, 0);  prog[2][1] = addi(2, 0, 3);
        prog[2][2] = addi(1, 1, 1);  prog[2][3] = bne(1, 2, -4);
        prog[2][4] = addi(30, 0, 1); plen[2] = 5;
        prog[3][0] = addi(1, 0, 9);  prog[3][1] = sw(1, 0, 4);
        prog[3][2] = lw(3, 0, 4);    prog[3][3] = addi(30, 0, 1);  plen[3] = 4;

        vecs[0]  = '{0, 1, 32'd5};
        vecs[1]  = '{0, 2, 32'd8};
        vecs[2]  = '{0, 3, 32'd13};
        vecs[3]  = '{0, 30, 32'd1};
        vecs[4]  = '{1, 1, 32'd7};
        vecs[5]  = '{1, 2, 32'd14};
        vecs[6]  = '{2, 1, 32'd3};
        vecs[7]  = '{2, 2, 32'd3};
        vecs[8]  = '{2, 30, 32'd1};
        vecs[9]  = '{3, 1, 32'd9};
        vecs[10] = '{3, 3, 32'd9};
        vecs[11] = '{3, 0, 32'd0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset pc f1", pc1, 32'd0);
        chk("reset retire f1", {31'd0, ret1}, 32'd0);
        chk("reset halt f1", {31'd0, halt1}, 32'd0);
        chk("reset pc f0", pc0, 32'd0);
        chk("reset halt f0", {31'd0, halt0}, 32'd0);

        // Register results, both forwarding modes
        cur = -1;
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].p != cur) begin
                cur = vecs[i].p;
                start_prog(cur);
                wait_halt($sformatf("p%0d", cur));
            end
            dbg_ra = vecs[i].ra[4:0];
            #1;
            chk($sformatf("p%0d x%0d f1", vecs[i].p, vecs[i].ra), dbg1, vecs[i].exp);
            chk($sformatf("p%0d x%0d f0", vecs[i].p, vecs[i].ra), dbg0, vecs[i].exp);
        end

        // Dependent chain timing: first retire on edge 5; FORWARD=0 stalls 2 per pair
        start_prog(0);
        wait_halt("p0 timing");
        exp_q = '{5, 6, 7, 8};
        chk_q("p0 retire f1", ret_q1, exp_q);
        exp_q = '{5, 8, 11, 12};
        chk_q("p0 retire f0", ret_q0, exp_q);
        chk("p0 halt cycle f1", hc1, 8);
        chk("p0 halt cycle f0", hc0, 12);
        chk("p0 f0 slower", {31'd0, hc0 > hc1}, 32'd1);

        // Load-use: exactly one bubble
        start_prog(1);
        wait_halt("p1 timing");
        exp_q = '{5, 7, 8};
        chk_q("p1 retire f1", ret_q1, exp_q);

        // Loop: 2-cycle gap after each taken branch, fall-through not squashed
        start_prog(2);
        wait_halt("p2 timing");
        exp_q = '{5, 6, 7, 8, 11, 12, 15, 16, 17};
        chk_q("p2 retire f1", ret_q1, exp_q);

        // Store then load; halt is sticky and freezes the pipe
        start_prog(3);
        wait_halt("p3 timing");
        exp_q = '{5, 6, 7, 8};
        chk_q("p3 retire f1", ret_q1, exp_q);
        chk("p3 dmem[1] f1", dut1.u_dmem.mem[1], 32'd9);
        chk("p3 dmem[1] f0", dut0.u_dmem.mem[1], 32'd9);
        chk("p3 halt pc f1", pc1, 32'd28);
        nret = ret_q1.size() + ret_q0.size();
        pc_snap = pc1;
        lowc = 0;
        repeat (20) begin
            @(negedge clk);
            if (!halt1 || !halt0) lowc++;
        end
        #1;
        chk("halt sticky", lowc, 0);
        chk("no retire after halt", ret_q1.size() + ret_q0.size(), nret);
        chk("pc frozen after halt", pc1, pc_snap);

        // Reset mid-loop, then the program re-runs to the same end state
        start_prog(2);
        n = 0;
        while (cyc != 11 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("retire before mid reset", {31'd0, ret1}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid reset pc f1", pc1, 32'd0);
        chk("mid reset retire f1", {31'd0, ret1}, 32'd0);
        chk("mid reset pc f0", pc0, 32'd0);
        @(negedge clk);
        ret_q1.delete();
        ret_q0.delete();
        hc1 = 0;
        hc0 = 0;
        rst = 1'b0;
        wait_halt("p2 rerun");
        exp_q = '{5, 6, 7, 8, 11, 12, 15, 16, 17};
        chk_q("p2 rerun retire f1", ret_q1, exp_q);
        dbg_ra = 5'd1;  #1;
        chk("rerun x1 f1", dbg1, 32'd3);
        chk("rerun x1 f0", dbg0, 32'd3);
        dbg_ra = 5'd30; #1;
        chk("rerun x30 f1", dbg1, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
